noc_wr_fifo: RTL and testbench
==============================

// Module: noc_wr_fifo
// PURPOSE
//  Write-posting buffer between a writing IP (ethernet writer, d$ writer) and one noc write port.
//  Accepts {addr,data} write requests on a valid/ready input and stores them in a small in-order FIFO.
//  Replays the requests on the noc wr_portN valid/ready interface.
//  Decouples the IP from arbitration stalls, so the IP is not held while the noc serves other ports.
// PARAMETERS
//  DATA_WIDTH_MSB  15  MSB of write data (width = DATA_WIDTH_MSB+1), matches noc
//  ADDR_WIDTH_MSB  15  MSB of write address, matches noc
//  DEPTH_LOG2      3   log2 of entry count; DEPTH = 2**DEPTH_LOG2 (default 8)
// PORTS
//  clk       in   1               clock; all state updates on posedge
//  rst       in   1               asynchronous, active-low reset
//  in_valid  in   1               IP write request valid
//  in_ready  out  1               buffer can accept (registered)
//  in_addr   in   ADDR_WIDTH_MSB+1  IP write address
//  in_data   in   DATA_WIDTH_MSB+1  IP write data
//  flush     in   1               synchronous discard of all buffered entries
//  wr_valid  out  1               request to noc write port
//  wr_ready  in   1               noc accepted head entry
//  wr_addr   out  ADDR_WIDTH_MSB+1  head entry address
//  wr_data   out  DATA_WIDTH_MSB+1  head entry data
//  level     out  DEPTH_LOG2+1    current entry count, 0..DEPTH
//  hwm       out  DEPTH_LOG2+1    peak level; only exists with NOC_WR_FIFO_HWM_EN
//  hwm_clr   in   1               reload hwm with level; only exists with NOC_WR_FIFO_HWM_EN
// BEHAVIOUR
//  Reset (rst=0, async):
//   - wr/rd pointers, level and hwm = 0; in_ready = 0; wr_valid = 0.
//   - wr_addr/wr_data are don't-care.
//   - in_ready rises on the first posedge after rst is released.
//  Push = in_valid & in_ready; pop = wr_valid & wr_ready; both are evaluated at the same posedge.
//  Pointers are DEPTH_LOG2+1 bits and wrap naturally.
//   - Empty: pointers equal.
//   - Full: index bits equal and MSBs differ.
//  in_ready is a register, set to (next_level < DEPTH).
//   - When level = DEPTH, push is refused even if a pop occurs in that cycle.
//   - in_ready reasserts on the cycle after the pop.
//  wr_valid = (level != 0). wr_addr/wr_data come from the head entry, first-word fall-through, no extra register stage.
//  Latency: a push at edge N into an empty FIFO gives wr_valid=1 after edge N; that word is poppable at edge N+1.
//  Simultaneous push & pop with 0 < level < DEPTH: both are taken; level is unchanged.
//  Push & pop at level 0: only the push is taken, because wr_valid=0 that cycle.
//  Output stability: while wr_valid & !wr_ready, wr_addr/wr_data/wr_valid hold unchanged until popped or flushed.
//  Upstream must hold in_addr/in_data while in_valid & !in_ready. The block does not check this.
//  Ordering is strict FIFO; no reordering, merging or dropping except on flush.
//  flush=1 (sync, highest priority):
//   - Pointers and level go to 0 at the edge.
//   - Any push or pop in that cycle is ignored; the pushed word is lost.
//   - wr_valid=0 from the next cycle; in_ready=1 from the next cycle.
//  Reset mid-operation: all contents are discarded; no partial entry is ever presented.
//  Storage is a flop/dist-RAM array of DEPTH x (ADDR+DATA) bits, written only on push.
// CONFIGURATION
//  NOC_WR_FIFO_HWM_EN defined:
//   - Adds hwm/hwm_clr. hwm <= max(hwm, next_level) each edge.
//   - hwm_clr=1: hwm <= next_level. hwm_clr wins over the max update.
//   - flush does not clear hwm.
//  NOC_WR_FIFO_HWM_EN undefined:
//   - hwm/hwm_clr ports and their logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset: rst=0 with in_valid=1 -> in_ready=0, wr_valid=0, level=0; release -> in_ready=1 one edge later.
//  2 Single write: addr=0x0040 data=0x1234, wr_ready=0 -> wr_valid=1 next cycle, outputs hold 10 cycles; wr_ready=1 -> popped, level 0.
//  3 Fill: 9 pushes with wr_ready=0, DEPTH=8 -> level=8, in_ready=0, 9th held; drain -> 8 words in push order, then 9th accepted.
//  4 Concurrent: level=3, push+pop same edge -> level=3; level=8, push+pop -> level=7, push refused.
//  5 Wrap: 40 writes data=0..39 with random in_valid/wr_ready -> all 40 emerged in order, none duplicated.
//  6 Flush: level=5, flush=1 with push same edge -> level=0, wr_valid=0 next cycle, word not emitted; HWM_EN: hwm stays 5, hwm_clr -> 0.

Source files
------------

// File: rtl/noc_wr_fifo_if.sv
// Valid/ready write-request channel ({addr,data}) shared by the IP side and the noc side
// of noc_wr_fifo. The master modport drives valid/addr/data; the slave modport drives ready.
interface noc_wr_fifo_if #(
  parameter int ADDR_WIDTH_MSB = 15,
  parameter int DATA_WIDTH_MSB = 15
);
  logic                    valid;
  logic                    ready;
  logic [ADDR_WIDTH_MSB:0] addr;
  logic [DATA_WIDTH_MSB:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/noc_wr_fifo.sv
// Write-posting FIFO between a writing IP and one noc write port.
// Optional peak-level tracking (hwm/hwm_clr) is enabled with NOC_WR_FIFO_HWM_EN.
module noc_wr_fifo #(
  parameter int DATA_WIDTH_MSB = 15,
  parameter int ADDR_WIDTH_MSB = 15,
  parameter int DEPTH_LOG2     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  noc_wr_fifo_if.slave        in_port,
  noc_wr_fifo_if.master       wr_port,
  output logic [DEPTH_LOG2:0] level
`ifdef NOC_WR_FIFO_HWM_EN
  ,
  output logic [DEPTH_LOG2:0] hwm,
  input  logic                hwm_clr
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int EW    = ADDR_WIDTH_MSB + DATA_WIDTH_MSB + 2;

  typedef logic [DEPTH_LOG2:0] ptr_t;

  ptr_t            wr_ptr;
  ptr_t            rd_ptr;
  ptr_t            next_level;
  logic            in_ready_q;
  logic            full;
  logic            push;
  logic            pop;
  logic [EW-1:0]   mem [DEPTH];

  assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign level = wr_ptr - rd_ptr;

  assign in_port.ready = in_ready_q;
  assign wr_port.valid = (level != '0);
  assign {wr_port.addr, wr_port.data} = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // in_ready is registered, so a pop at full only reopens the input one cycle later
  assign push = in_port.valid & in_ready_q & ~full & ~flush;
  assign pop  = wr_port.valid & wr_port.ready & ~flush;

  always_comb begin
    next_level = level;
    if (flush) begin
      next_level = '0;
    end else begin
      next_level = level + ptr_t'(push) - ptr_t'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      end
      in_ready_q <= (next_level < ptr_t'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {in_port.addr, in_port.data};
  end

`ifdef NOC_WR_FIFO_HWM_EN
  // hwm survives flush; only reset or hwm_clr lowers it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm <= '0;
    end else if (hwm_clr) begin
      hwm <= next_level;
    end else if (next_level > hwm) begin
      hwm <= next_level;
    end
  end
`endif

endmodule

// File: tb/tb_noc_wr_fifo.sv
// Randomized and directed bench for noc_wr_fifo against a queue-based reference model.
module tb_noc_wr_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] level;
`ifdef NOC_WR_FIFO_HWM_EN
  logic [3:0] hwm;
  logic       hwm_clr = 1'b0;
`endif

  noc_wr_fifo_if in_if ();
  noc_wr_fifo_if wr_if ();

  noc_wr_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_port (in_if),
    .wr_port (wr_if),
    .level   (level)
`ifdef NOC_WR_FIFO_HWM_EN
    ,
    .hwm     (hwm),
    .hwm_clr (hwm_clr)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] q[$];
  logic [31:0] emitted[$];
  bit          m_ready = 0;
  int          m_hwm = 0;
  bit          last_push = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("level", 32'(level), 32'(q.size()));
    chk("wr_valid", 32'(wr_if.valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_if.ready), 32'(m_ready));
    if (q.size() != 0) begin
      chk("wr_addr", 32'(wr_if.addr), 32'(q[0][31:16]));
      chk("wr_data", 32'(wr_if.data), 32'(q[0][15:0]));
    end
`ifdef NOC_WR_FIFO_HWM_EN
    chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
  endtask

  // Reference behaviour at a clock edge: queue semantics plus the one-cycle-late input gate.
  task automatic update_model();
    bit clr;
    bit do_push;
    bit do_pop;
    clr = 0;
`ifdef NOC_WR_FIFO_HWM_EN
    clr = hwm_clr;
`endif
    last_push = 0;
    if (!rst) begin
      q.delete();
      m_ready = 0;
      m_hwm = 0;
    end else begin
      do_push = in_if.valid && m_ready && !flush;
      do_pop  = (q.size() != 0) && wr_if.ready && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) emitted.push_back(q.pop_front());
        if (do_push) q.push_back({in_if.addr, in_if.data});
      end
      last_push = do_push;
      m_ready = (q.size() < DEPTH);
      if (clr) m_hwm = q.size();
      else if (q.size() > m_hwm) m_hwm = q.size();
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic push_word(input logic [15:0] a, input logic [15:0] d, input string tag);
    in_if.valid = 1'b1;
    in_if.addr  = a;
    in_if.data  = d;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (last_push) break;
    end
    chk(tag, 32'(last_push), 32'd1);
    in_if.valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    wr_if.ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    cycle();
    chk(tag, 32'(level), 32'd0);
    wr_if.ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int n;
    in_if.valid = 1'b1;
    in_if.addr  = 16'h0;
    in_if.data  = 16'h0;
    wr_if.ready = 1'b0;

    // reset held with valid asserted
    #2;
    chk("rst_in_ready", 32'(in_if.ready), 32'd0);
    chk("rst_wr_valid", 32'(wr_if.valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    cycle();
    cycle();
    rst = 1'b1;
    chk("rel_in_ready_low", 32'(in_if.ready), 32'd0);
    in_if.valid = 1'b0;
    cycle();
    chk("rel_in_ready_high", 32'(in_if.ready), 32'd1);

    // single write, held 10 cycles, then popped
    in_if.valid = 1'b1;
    in_if.addr  = 16'h0040;
    in_if.data  = 16'h1234;
    cycle();
    in_if.valid = 1'b0;
    chk("t2_valid", 32'(wr_if.valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t2_hold", {wr_if.addr, wr_if.data}, 32'h0040_1234);
    end
    wr_if.ready = 1'b1;
    cycle();
    wr_if.ready = 1'b0;
    chk("t2_level", 32'(level), 32'd0);

    // fill past depth, then drain with the 9th word still offered
    emitted.delete();
    for (int i = 0; i < 8; i++) push_word(16'(16'h100 + i), 16'(16'hA000 + i), "t3_push");
    in_if.valid = 1'b1;
    in_if.addr  = 16'h0108;
    in_if.data  = 16'hA008;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_refused", 32'(last_push), 32'd0);
    end
    chk("t3_full_level", 32'(level), 32'd8);
    chk("t3_full_ready", 32'(in_if.ready), 32'd0);
    wr_if.ready = 1'b1;
    cycle();
    chk("t4_full_pushpop_level", 32'(level), 32'd7);
    chk("t4_full_push_refused", 32'(last_push), 32'd0);
    for (int i = 0; i < 50; i++) begin
      if (last_push) break;
      cycle();
    end
    chk("t3_ninth_taken", 32'(last_push), 32'd1);
    in_if.valid = 1'b0;
    drain("t3_drained");
    chk("t3_count", 32'(emitted.size()), 32'd9);
    n = emitted.size();
    for (int i = 0; i < n && i < 9; i++)
      chk("t3_order", emitted[i], {16'(16'h100 + i), 16'(16'hA000 + i)});

    // push+pop at a mid level
    for (int i = 0; i < 3; i++) push_word(16'(16'h200 + i), 16'(i), "t4_push");
    in_if.valid = 1'b1;
    in_if.addr  = 16'h0203;
    in_if.data  = 16'h0003;
    wr_if.ready = 1'b1;
    cycle();
    chk("t4_mid_level", 32'(level), 32'd3);
    in_if.valid = 1'b0;
    drain("t4_drained");

    // 40 sequenced words with random handshakes
    emitted.delete();
    idx = 0;
    for (int c = 0; c < 3000; c++) begin
      if (idx == 40 && q.size() == 0) break;
      in_if.valid = (idx < 40) && ($urandom_range(1, 0) == 1);
      in_if.addr  = 16'(idx * 4);
      in_if.data  = 16'(idx);
      wr_if.ready = ($urandom_range(1, 0) == 1);
      cycle();
      if (last_push) idx++;
    end
    in_if.valid = 1'b0;
    wr_if.ready = 1'b0;
    chk("t5_count", 32'(emitted.size()), 32'd40);
    n = emitted.size();
    for (int i = 0; i < n && i < 40; i++)
      chk("t5_order", emitted[i], {16'(i * 4), 16'(i)});

    // random mix including flush and hwm_clr
    for (int c = 0; c < 400; c++) begin
      in_if.valid = ($urandom_range(3, 0) != 0);
      in_if.addr  = 16'($urandom);
      in_if.data  = 16'($urandom);
      wr_if.ready = ($urandom_range(2, 0) == 0);
      flush       = ($urandom_range(15, 0) == 0);
`ifdef NOC_WR_FIFO_HWM_EN
      hwm_clr     = ($urandom_range(15, 0) == 0);
`endif
      cycle();
    end
    flush = 1'b0;
    in_if.valid = 1'b0;
`ifdef NOC_WR_FIFO_HWM_EN
    hwm_clr = 1'b0;
`endif
    drain("rand_drained");

    // reset mid-operation
    for (int i = 0; i < 4; i++) push_word(16'(16'h300 + i), 16'(i), "rst_push");
    rst = 1'b0;
    q.delete();
    m_ready = 0;
    m_hwm = 0;
    #1;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_wr_valid", 32'(wr_if.valid), 32'd0);
    chk("midrst_in_ready", 32'(in_if.ready), 32'd0);
    cycle();
    rst = 1'b1;
    cycle();
    cycle();

    // flush at level 5 with a simultaneous push
`ifdef NOC_WR_FIFO_HWM_EN
    hwm_clr = 1'b1;
    cycle();
    hwm_clr = 1'b0;
`endif
    for (int i = 0; i < 5; i++) push_word(16'(16'h400 + i), 16'(i), "t6_push");
    chk("t6_level5", 32'(level), 32'd5);
    flush       = 1'b1;
    in_if.valid = 1'b1;
    in_if.addr  = 16'h0500;
    in_if.data  = 16'hBEEF;
    cycle();
    flush       = 1'b0;
    in_if.valid = 1'b0;
    chk("t6_level0", 32'(level), 32'd0);
    chk("t6_wr_valid", 32'(wr_if.valid), 32'd0);
    chk("t6_in_ready", 32'(in_if.ready), 32'd1);
`ifdef NOC_WR_FIFO_HWM_EN
    chk("t6_hwm_kept", 32'(hwm), 32'd5);
`endif
    emitted.delete();
    wr_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    wr_if.ready = 1'b0;
    chk("t6_nothing_emitted", 32'(emitted.size()), 32'd0);
`ifdef NOC_WR_FIFO_HWM_EN
    hwm_clr = 1'b1;
    cycle();
    hwm_clr = 1'b0;
    chk("t6_hwm_clr", 32'(hwm), 32'd0);
`endif
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
